// File: rtl/snn_mem_pkg.sv
// snn_mem_pkg: op encodings, SRAM geometry and the saturating adder shared by
// the SRAM access path. Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

package snn_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  localparam int SRAM_AW = 13;
  localparam int SRAM_DW = 32;

  // Signed 32-bit add; when i_sat is set, overflow clamps to the nearest rail.
  function automatic logic [31:0] sat_add32(input logic [31:0] i_a,
                                            input logic [31:0] i_b,
                                            input logic        i_sat);
    logic [31:0] w_s;
    logic        w_ovf;
    w_s   = i_a + i_b;
    w_ovf = (i_a[31] == i_b[31]) && (w_s[31] != i_a[31]);
    if (i_sat && w_ovf)
      return i_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return w_s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the pointer holds the last
// granted requester, which loses a tie on the next contested cycle. Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= 1'b0;
    else if (i_adv && (|o_gnt))
      r_ptr <= o_gnt[1];
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between two requesters with
// round-robin grant and an atomic two-cycle fetch-and-add. Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

module sram_arbiter
  import snn_mem_pkg::*;
#(
  parameter int AW  = SRAM_AW,
  parameter int DW  = SRAM_DW,
  parameter int SAT = 1
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [1:0]    p0_op,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [1:0]    p1_op,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_delta;
  logic          r_port;
  logic [1:0]    r_rvalid;

  logic          w_idle;
  logic          w_rmw;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_hs;
  logic          w_sel;
  logic [1:0]    w_op;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_sum;

  // RST_N gates the request path so the SRAM pins stay quiet throughout reset.
  assign w_idle  = RST_N && (r_state == S_IDLE);
  assign w_rmw   = RST_N && (r_state == S_RMW_WR);
  assign w_req   = {p1_valid, p0_valid} & {2{w_idle}};
  assign w_hs    = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_op    = w_sel ? p1_op    : p0_op;
  assign w_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;
  assign w_sum   = sat_add32(sram_q, r_delta, SAT != 0);

  rr_arb2 u_arb (
    .clk   (CK),
    .rst_n (RST_N),
    .i_req (w_req),
    .i_adv (w_hs),
    .o_gnt (w_gnt)
  );

  assign p0_ready  = w_gnt[0];
  assign p1_ready  = w_gnt[1];
  assign p0_rdata  = sram_q;
  assign p1_rdata  = sram_q;
  assign p0_rvalid = r_rvalid[0] || (w_rmw && !r_port);
  assign p1_rvalid = r_rvalid[1] || (w_rmw &&  r_port);

  always_comb begin
    sram_cs = 1'b0;
    sram_we = 1'b0;
    sram_a  = w_addr;
    sram_d  = w_wdata;
    if (w_rmw) begin
      sram_cs = 1'b1;
      sram_we = 1'b1;
      sram_a  = r_addr;
      sram_d  = w_sum;
    end else if (w_hs) begin
      sram_cs = 1'b1;
      sram_we = (w_op == OP_WRITE);
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_delta  <= '0;
      r_port   <= 1'b0;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= 2'b00;
      // ADD responds from the RMW_WR cycle instead, alongside the write-back.
      if (w_hs && (w_op != OP_WRITE) && (w_op != OP_ADD))
        r_rvalid[w_sel] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_hs && (w_op == OP_ADD)) begin
            r_state <= S_RMW_WR;
            r_addr  <= w_addr;
            r_delta <= w_wdata;
            r_port  <= w_sel;
          end
        end
        S_RMW_WR: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
